// File: rtl/game_tick_ctrl.sv
// Dino game timing scheduler: run-gated frame/scroll/animation enable strobes plus speed level.
// Optional macro TICK_SPEEDUP_EN builds the level stepper; without it level is 0 and scroll uses SCROLL_BASE.
module game_tick_ctrl #(
  parameter int DIV_W             = 21,
  parameter int FRAME_DIV         = 1666667,
  parameter int SCROLL_BASE       = 8,
  parameter int ANIM_DIV          = 6,
  parameter int SPEED_STEP_FRAMES = 600,
  parameter int MAX_LEVEL         = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        collide,
  output logic        frame_tick,
  output logic        scroll_tick,
  output logic        anim_tick,
  output logic [2:0]  level,
  output logic [1:0]  state,
  output logic [15:0] frames
);

  localparam int SCROLL_W = $clog2(SCROLL_BASE + 1);
  localparam int ANIM_W   = $clog2(ANIM_DIV + 1);

  localparam logic [DIV_W-1:0]    FRAME_LAST   = DIV_W'(FRAME_DIV - 1);
  localparam logic [SCROLL_W-1:0] SCROLL_LAST0 = SCROLL_W'(SCROLL_BASE - 1);
  localparam logic [ANIM_W-1:0]   ANIM_LAST    = ANIM_W'(ANIM_DIV - 1);

  // Elaboration-time guard on the parameter ranges the counters rely on.
  if (FRAME_DIV < 2 || SCROLL_BASE - MAX_LEVEL < 1 || MAX_LEVEL > 7 || MAX_LEVEL < 0 ||
      ANIM_DIV < 1 || SPEED_STEP_FRAMES < 1) begin : g_bad_cfg
    $error("game_tick_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t              state_reg, state_next;
  logic                restart;
  logic [DIV_W-1:0]    frame_cnt_reg;
  logic [SCROLL_W-1:0] scroll_cnt_reg;
  logic [SCROLL_W-1:0] scroll_last;
  logic [ANIM_W-1:0]   anim_cnt_reg;
  logic [15:0]         frames_reg;
  logic [2:0]          level_reg;

  always_comb begin
    state_next = state_reg;
    restart    = 1'b0;
    case (state_reg)
      IDLE, OVER: begin
        if (start) begin
          state_next = RUN;
          restart    = 1'b1;
        end
      end
      RUN: begin
        if (collide)    state_next = OVER;
        else if (pause) state_next = PAUSE;
      end
      PAUSE: begin
        if (pause) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes decode registered state only, so they are glitch-free and zero-latency.
  assign scroll_last = SCROLL_LAST0 - SCROLL_W'(level_reg);
  assign frame_tick  = (state_reg == RUN) && (frame_cnt_reg == FRAME_LAST);
  assign scroll_tick = frame_tick && (scroll_cnt_reg >= scroll_last);
  assign anim_tick   = frame_tick && (anim_cnt_reg == ANIM_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      frame_cnt_reg  <= '0;
      scroll_cnt_reg <= '0;
      anim_cnt_reg   <= '0;
      frames_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (restart) begin
        frame_cnt_reg  <= '0;
        scroll_cnt_reg <= '0;
        anim_cnt_reg   <= '0;
        frames_reg     <= '0;
      end else begin
        case (state_reg)
          RUN: begin
            if (frame_tick) begin
              frame_cnt_reg  <= '0;
              scroll_cnt_reg <= scroll_tick ? '0 : scroll_cnt_reg + SCROLL_W'(1);
              anim_cnt_reg   <= anim_tick ? '0 : anim_cnt_reg + ANIM_W'(1);
              if (frames_reg != 16'hFFFF) frames_reg <= frames_reg + 16'd1;
            end else begin
              frame_cnt_reg <= frame_cnt_reg + DIV_W'(1);
            end
          end
          PAUSE: ;
          default: frame_cnt_reg <= '0;
        endcase
      end
    end
  end

`ifdef TICK_SPEEDUP_EN
  localparam int STEP_W = $clog2(SPEED_STEP_FRAMES + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPEED_STEP_FRAMES - 1);
  localparam logic [2:0]        MAX_LVL   = 3'(MAX_LEVEL);

  logic [STEP_W-1:0] step_cnt_reg;

  // Level changes on the same edge as the frame_tick that completes a step, so it affects the next frame.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      step_cnt_reg <= '0;
      level_reg    <= '0;
    end else if (frame_tick) begin
      if (step_cnt_reg == STEP_LAST) begin
        step_cnt_reg <= '0;
        if (level_reg != MAX_LVL) level_reg <= level_reg + 3'd1;
      end else begin
        step_cnt_reg <= step_cnt_reg + STEP_W'(1);
      end
    end
  end
`else
  assign level_reg = 3'd0;
`endif

  assign level  = level_reg;
  assign state  = state_reg;
  assign frames = frames_reg;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// Randomized self-checking bench for game_tick_ctrl against a frame-level behavioural model.
module tb_game_tick_ctrl;

  localparam int FD  = 4;
  localparam int SB  = 4;
  localparam int AD  = 3;
  localparam int SSF = 5;
  localparam int ML  = 2;
`ifdef TICK_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        collide = 1'b0;
  logic        frame_tick, scroll_tick, anim_tick;
  logic [2:0]  level;
  logic [1:0]  state;
  logic [15:0] frames;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: game state, cycle position within the frame, frames since start, frames since last scroll.
  int m_state = 0;
  int m_phase = 0;
  int m_total = 0;
  int m_since = 0;

  always #5 clk = ~clk;

  game_tick_ctrl #(
    .DIV_W(4), .FRAME_DIV(FD), .SCROLL_BASE(SB), .ANIM_DIV(AD),
    .SPEED_STEP_FRAMES(SSF), .MAX_LEVEL(ML)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .collide(collide),
    .frame_tick(frame_tick), .scroll_tick(scroll_tick), .anim_tick(anim_tick),
    .level(level), .state(state), .frames(frames)
  );

  function automatic int m_level();
    int l;
    l = m_total / SSF;
    if (l > ML) l = ML;
    return SPEEDUP ? l : 0;
  endfunction

  function automatic bit m_ft();
    return (m_state == 1) && (m_phase == FD - 1);
  endfunction

  function automatic bit m_st();
    return m_ft() && (m_since + 1 >= SB - m_level());
  endfunction

  function automatic bit m_at();
    return m_ft() && ((m_total % AD) == AD - 1);
  endfunction

  function automatic logic [23:0] exp_vec();
    int f;
    f = (m_total > 65535) ? 65535 : m_total;
    return {m_ft(), m_st(), m_at(), 3'(m_level()), 2'(m_state), 16'(f)};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {frame_tick, scroll_tick, anim_tick, level, state, frames};
  endfunction

  // One clock: drive pulses, advance the model from pre-edge values, settle 1 time unit past the edge.
  task automatic drive(input bit s, input bit p, input bit c, input bit r);
    bit ft, st;
    start = s; pause = p; collide = c; rst = r;
    ft = m_ft();
    st = m_st();
    @(posedge clk);
    if (r) begin
      m_state = 0; m_phase = 0; m_total = 0; m_since = 0;
    end else begin
      if (ft) begin
        m_total++;
        m_since = st ? 0 : m_since + 1;
      end
      case (m_state)
        1: begin
          m_phase = (m_phase + 1) % FD;
          if (c) m_state = 3;
          else if (p) m_state = 2;
        end
        2: if (p) m_state = 1;
        default: begin
          m_phase = 0;
          if (s) begin
            m_state = 1; m_total = 0; m_since = 0; m_phase = 0;
          end
        end
      endcase
    end
    #1;
    start = 1'b0; pause = 1'b0; collide = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    n_cmp++;
    if (dut_vec() !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_state: got %h required %h", dut_vec(), 24'h0);
    end
    // Stray pause/collide pulses must not disturb IDLE.
    for (int i = 0; i < 20; i++) begin
      drive(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL idle_hold cyc %0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_run_frames();
    int first_tick, ticks;
    first_tick = -1;
    ticks = 0;
    drive(1, 0, 0, 0);
    for (int cyc = 1; cyc <= 15 * FD; cyc++) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL run_frames cyc %0d: got %h required %h", cyc, dut_vec(), exp_vec());
      end
      if (frame_tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = cyc;
      end
      // A stray start while running must be ignored.
      drive((cyc == 7), 0, 0, 0);
    end
    n_cmp++;
    if (first_tick != FD) begin
      n_bad++;
      $display("FAIL first_tick_latency: got %0d required %0d", first_tick, FD);
    end
    n_cmp++;
    if (ticks != 15 || frames !== 16'd15) begin
      n_bad++;
      $display("FAIL frame_count: got ticks=%0d frames=%0d required 15", ticks, frames);
    end
    n_cmp++;
    if (level !== (SPEEDUP ? 3'd2 : 3'd0)) begin
      n_bad++;
      $display("FAIL level_saturate: got %0d required %0d", level, SPEEDUP ? 2 : 0);
    end
  endtask

  task automatic test_pause();
    logic [15:0] held;
    int guard;
    guard = 0;
    while (!m_ft() && guard < 2 * FD) begin
      drive(0, 0, 0, 0);
      guard++;
    end
    n_cmp++;
    if (frame_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL pause_sync: got frame_tick=%b required 1", frame_tick);
    end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);
    held = frames;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (dut_vec() !== exp_vec() || frame_tick !== 1'b0) begin
        n_bad++;
        $display("FAIL paused cyc %0d: got %h required %h", i, dut_vec(), exp_vec());
      end
      drive($urandom_range(0, 1), 0, $urandom_range(0, 1), 0);
    end
    drive(0, 1, 0, 0);
    n_cmp++;
    if (frames !== held || state !== 2'b01) begin
      n_bad++;
      $display("FAIL pause_resume: got frames=%0d state=%b required frames=%0d state=01",
               frames, state, held);
    end
    for (int i = 0; i < 3 * FD; i++) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL resume cyc %0d: got %h required %h", i, dut_vec(), exp_vec());
      end
      drive(0, 0, 0, 0);
    end
  endtask

  task automatic test_collide();
    logic [15:0] held;
    int guard;
    guard = 0;
    while (!m_ft() && guard < 2 * FD) begin
      drive(0, 0, 0, 0);
      guard++;
    end
    n_cmp++;
    if (frame_tick !== 1'b1 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL collide_tick: got %h required %h", dut_vec(), exp_vec());
    end
    // collide and pause together: collide wins, tick in this cycle still counts.
    drive(0, 1, 1, 0);
    held = frames;
    n_cmp++;
    if (state !== 2'b11 || frame_tick !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL collide_over: got %h required %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
      n_cmp++;
      if (frames !== held || state !== 2'b11 || dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL over_hold cyc %0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    drive(1, 0, 0, 0);
    n_cmp++;
    if (state !== 2'b01 || frames !== 16'd0 || level !== 3'd0) begin
      n_bad++;
      $display("FAIL restart: got state=%b frames=%0d level=%0d required 01/0/0",
               state, frames, level);
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 9 * FD + 1; i++) drive(0, 0, 0, 0);
    drive(1, 1, 1, 1);
    n_cmp++;
    if (dut_vec() !== 24'h0) begin
      n_bad++;
      $display("FAIL rst_mid: got %h required %h", dut_vec(), 24'h0);
    end
  endtask

  task automatic test_random();
    bit s, p, c, r;
    for (int i = 0; i < 4000; i++) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        if (n_bad <= 20)
          $display("FAIL random cyc %0d: got %h required %h", i, dut_vec(), exp_vec());
      end
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 29) == 0);
      p = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 119) == 0);
      drive(s, p, c, r);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_run_frames();
    test_pause();
    test_collide();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
